// File: rtl/accum_bank_pkg.sv
// accum_bank_pkg: shared types and helpers for the accumulator bank.
//   state_e     - readout FSM state (ACCUM, DUMP)
//   chan_width  - bit width of a channel index for a given channel count
package accum_bank_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } state_e;

  // Never narrower than one bit so a port declared with it stays legal.
  function automatic int unsigned chan_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accum_sat_add.sv
// accum_sat_add: combinational accumulator adder.
// Adds a zero-extended unsigned summand to an accumulator value.
// Build option: ACCUM_BANK_SAT_EN clamps an overflowing sum to all-ones;
// without it the sum wraps modulo 2^p_ACC_WIDTH. carry is identical in both builds.
// Ports:
//   acc     in  p_ACC_WIDTH   current accumulator value
//   summand in  p_DATA_WIDTH  unsigned summand
//   sum     out p_ACC_WIDTH   new accumulator value
//   carry   out 1             carry out of the p_ACC_WIDTH addition
module accum_sat_add #(
  parameter int unsigned p_DATA_WIDTH = 8,
  parameter int unsigned p_ACC_WIDTH  = 16
) (
  input  logic [p_ACC_WIDTH-1:0]  acc,
  input  logic [p_DATA_WIDTH-1:0] summand,
  output logic [p_ACC_WIDTH-1:0]  sum,
  output logic                    carry
);

  logic [p_ACC_WIDTH:0] full;

  assign full  = {1'b0, acc} + {{(p_ACC_WIDTH + 1 - p_DATA_WIDTH){1'b0}}, summand};
  assign carry = full[p_ACC_WIDTH];

`ifdef ACCUM_BANK_SAT_EN
  assign sum = carry ? {p_ACC_WIDTH{1'b1}} : full[p_ACC_WIDTH-1:0];
`else
  assign sum = full[p_ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/accum_bank.sv
// accum_bank: bank of p_CHANNELS independent unsigned accumulators with
// sticky overflow flags and a sequential, handshaked readout.
// In ACCUM the bank accepts summands (one per cycle, shared adder). i_DUMP
// moves to DUMP, where channels 0..p_CHANNELS-1 are presented on registered
// outputs; each handshake clears the presented channel.
// Build option: ACCUM_BANK_SAT_EN selects saturating instead of wrapping adds.
// Ports:
//   i_CLK, i_RST_N   clock (rising edge), asynchronous active-low reset
//   i_CLR            synchronous clear of all channels, aborts readout
//   i_VALID/o_READY  summand handshake; i_CHAN, i_SUMMAND carry the summand
//   i_DUMP           start readout
//   o_VALID/i_READY  readout handshake; o_CHAN, o_ACCUMULATION, o_OVERFLOW
//   o_BUSY           readout in progress
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter int unsigned p_DATA_WIDTH = 8,
  parameter int unsigned p_ACC_WIDTH  = 16,
  parameter int unsigned p_CHANNELS   = 4
) (
  input  logic                                   i_CLK,
  input  logic                                   i_RST_N,
  input  logic                                   i_CLR,
  input  logic                                   i_VALID,
  output logic                                   o_READY,
  input  logic [chan_width(p_CHANNELS)-1:0]      i_CHAN,
  input  logic [p_DATA_WIDTH-1:0]                i_SUMMAND,
  input  logic                                   i_DUMP,
  output logic                                   o_VALID,
  input  logic                                   i_READY,
  output logic [chan_width(p_CHANNELS)-1:0]      o_CHAN,
  output logic [p_ACC_WIDTH-1:0]                 o_ACCUMULATION,
  output logic                                   o_OVERFLOW,
  output logic                                   o_BUSY
);

  localparam int unsigned CW = chan_width(p_CHANNELS);
  localparam logic [CW-1:0] LastChan = CW'(p_CHANNELS - 1);

  state_e                 state_q, state_d;
  logic [p_ACC_WIDTH-1:0] acc_q [p_CHANNELS];
  logic [p_ACC_WIDTH-1:0] acc_d [p_CHANNELS];
  logic [p_CHANNELS-1:0]  ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic [CW-1:0]          chan_q, chan_d;
  logic [p_ACC_WIDTH-1:0] word_q, word_d;
  logic                   wovf_q, wovf_d;

  logic [p_ACC_WIDTH-1:0] sel_acc;
  logic [p_ACC_WIDTH-1:0] add_sum;
  logic                   add_carry;
  logic [CW-1:0]          rd_idx;
  logic [p_ACC_WIDTH-1:0] rd_acc;
  logic                   rd_ovf;

  // Operand select for the shared adder; an out-of-range channel reads 0
  // and is never written back.
  always_comb begin
    sel_acc = '0;
    for (int i = 0; i < int'(p_CHANNELS); i++) begin
      if (i_CHAN == CW'(i)) sel_acc = acc_q[i];
    end
  end

  accum_sat_add #(
    .p_DATA_WIDTH (p_DATA_WIDTH),
    .p_ACC_WIDTH  (p_ACC_WIDTH)
  ) u_add (
    .acc     (sel_acc),
    .summand (i_SUMMAND),
    .sum     (add_sum),
    .carry   (add_carry)
  );

  // Channel to load into the output registers: 0 on the first DUMP cycle,
  // otherwise the one after the word being presented.
  assign rd_idx = valid_q ? (chan_q + CW'(1)) : '0;

  always_comb begin
    rd_acc = '0;
    rd_ovf = 1'b0;
    for (int i = 0; i < int'(p_CHANNELS); i++) begin
      if (rd_idx == CW'(i)) begin
        rd_acc = acc_q[i];
        rd_ovf = ovf_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    word_d  = word_q;
    wovf_d  = wovf_q;

    if (i_CLR) begin
      for (int i = 0; i < int'(p_CHANNELS); i++) acc_d[i] = '0;
      ovf_d   = '0;
      state_d = ACCUM;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (i_VALID) begin
            for (int i = 0; i < int'(p_CHANNELS); i++) begin
              if (i_CHAN == CW'(i)) begin
                acc_d[i] = add_sum;
                if (add_carry) ovf_d[i] = 1'b1;
              end
            end
          end
          if (i_DUMP) state_d = DUMP;
        end
        DUMP: begin
          if (!valid_q) begin
            valid_d = 1'b1;
            chan_d  = '0;
            word_d  = rd_acc;
            wovf_d  = rd_ovf;
          end else if (i_READY) begin
            for (int i = 0; i < int'(p_CHANNELS); i++) begin
              if (chan_q == CW'(i)) begin
                acc_d[i] = '0;
                ovf_d[i] = 1'b0;
              end
            end
            if (chan_q == LastChan) begin
              valid_d = 1'b0;
              state_d = ACCUM;
            end else begin
              chan_d = rd_idx;
              word_d = rd_acc;
              wovf_d = rd_ovf;
            end
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= ACCUM;
      for (int i = 0; i < int'(p_CHANNELS); i++) acc_q[i] <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      word_q  <= '0;
      wovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      word_q  <= word_d;
      wovf_q  <= wovf_d;
    end
  end

  assign o_READY        = (state_q == ACCUM);
  assign o_BUSY         = (state_q == DUMP);
  assign o_VALID        = valid_q;
  assign o_CHAN         = chan_q;
  assign o_ACCUMULATION = word_q;
  assign o_OVERFLOW     = wovf_q;

endmodule

// File: tb/tb_accum_bank.sv
// tb_accum_bank: directed, table-driven bench for accum_bank
// (p_DATA_WIDTH=8, p_ACC_WIDTH=10, p_CHANNELS=4). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_accum_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, valid_in, dump, ready_in;
  logic [1:0] chan_in;
  logic [7:0] summand;
  logic       ready_out, valid_out, ovf_out, busy_out;
  logic [1:0] chan_out;
  logic [9:0] acc_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accum_bank #(
    .p_DATA_WIDTH (8),
    .p_ACC_WIDTH  (10),
    .p_CHANNELS   (4)
  ) dut (
    .i_CLK          (clk),
    .i_RST_N        (rst_n),
    .i_CLR          (clr),
    .i_VALID        (valid_in),
    .o_READY        (ready_out),
    .i_CHAN         (chan_in),
    .i_SUMMAND      (summand),
    .i_DUMP         (dump),
    .o_VALID        (valid_out),
    .i_READY        (ready_in),
    .o_CHAN         (chan_out),
    .o_ACCUMULATION (acc_out),
    .o_OVERFLOW     (ovf_out),
    .o_BUSY         (busy_out)
  );

  typedef struct {
    logic       clr, valid;
    logic [1:0] chan;
    logic [7:0] summand;
    logic       dump, ready;
    logic       ev;
    logic [1:0] ech;
    logic [9:0] eacc;
    logic       eovf, ebusy, erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic v, logic [1:0] ch, logic [7:0] s, logic d,
                              logic r, logic ev, logic [1:0] ech, logic [9:0] eacc,
                              logic eovf, logic ebusy, logic erdy);
    vec_t t;
    t.clr = c; t.valid = v; t.chan = ch; t.summand = s; t.dump = d; t.ready = r;
    t.ev = ev; t.ech = ech; t.eacc = eacc; t.eovf = eovf; t.ebusy = ebusy; t.erdy = erdy;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic v, input logic [1:0] ch,
                       input logic [7:0] s, input logic d, input logic r);
    clr = c; valid_in = v; chan_in = ch; summand = s; dump = d; ready_in = r;
  endtask

  task automatic add(input logic [1:0] ch, input logic [7:0] s);
    drive(1'b0, 1'b1, ch, s, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
  endtask

  // Full dump with i_READY held high; checks every word and the return to ACCUM.
  task automatic do_dump(input string tag, input logic [9:0] e0, input logic [9:0] e1,
                         input logic [9:0] e2, input logic [9:0] e3, input logic [3:0] eo);
    logic [9:0] ea [4];
    ea[0] = e0; ea[1] = e1; ea[2] = e2; ea[3] = e3;
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1);
    tick();
    check({tag, ".entry_busy"}, busy_out, 1);
    check({tag, ".entry_valid"}, valid_out, 0);
    dump = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("%s.w%0d.valid", tag, c), valid_out, 1);
      check($sformatf("%s.w%0d.chan", tag, c), chan_out, c);
      check($sformatf("%s.w%0d.acc", tag, c), acc_out, ea[c]);
      check($sformatf("%s.w%0d.ovf", tag, c), ovf_out, eo[c]);
    end
    tick();
    check({tag, ".end_valid"}, valid_out, 0);
    check({tag, ".end_busy"}, busy_out, 0);
    check({tag, ".end_ready"}, ready_out, 1);
    ready_in = 1'b0;
  endtask

  initial begin
    logic [9:0] ovf_exp;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    #3;
    check("rst.valid", valid_out, 0);
    check("rst.chan", chan_out, 0);
    check("rst.acc", acc_out, 0);
    check("rst.ovf", ovf_out, 0);
    check("rst.busy", busy_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.ready", ready_out, 1);

    // Add 3,4,5 to ch2 and dump; dump again to show ch2 was cleared;
    // then ch0 += 7 in the same cycle as i_DUMP.
    //                 clr v  ch s   d  r    ev ech acc ovf busy rdy
    vecs.push_back(mk(0, 1, 2, 3,   0, 0,   0, 0, 0,   0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 4,   0, 0,   0, 0, 0,   0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 5,   0, 0,   0, 0, 0,   0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   1, 0,   0, 0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 1, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 2, 12,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 3, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   0, 0, 0,   0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1,   0, 0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 1, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 2, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 3, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   0, 0, 0,   0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 7,   1, 0,   0, 0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 0, 7,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 1, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 2, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   1, 3, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 1,   0, 0, 0,   0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].valid, vecs[i].chan, vecs[i].summand, vecs[i].dump,
            vecs[i].ready);
      tick();
      check($sformatf("vec%0d.valid", i), valid_out, vecs[i].ev);
      check($sformatf("vec%0d.busy", i), busy_out, vecs[i].ebusy);
      check($sformatf("vec%0d.ready", i), ready_out, vecs[i].erdy);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d.chan", i), chan_out, vecs[i].ech);
        check($sformatf("vec%0d.acc", i), acc_out, vecs[i].eacc);
        check($sformatf("vec%0d.ovf", i), ovf_out, vecs[i].eovf);
      end
    end
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);

    // Overflow: 5 x 255 into ch1 = 1275, past 1023.
`ifdef ACCUM_BANK_SAT_EN
    ovf_exp = 10'd1023;
`else
    ovf_exp = 10'd251;
`endif
    for (int k = 0; k < 5; k++) add(2'd1, 8'd255);
    do_dump("ovf", 10'd0, ovf_exp, 10'd0, 10'd0, 4'b0010);

    // Back-pressure on ch0 with summands offered during the stall.
    add(2'd0, 8'd9);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'd0, 8'd50, 1'b0, 1'b0);
    tick();
    check("stall.first_valid", valid_out, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d.valid", k), valid_out, 1);
      check($sformatf("stall%0d.chan", k), chan_out, 0);
      check($sformatf("stall%0d.acc", k), acc_out, 9);
      check($sformatf("stall%0d.ready", k), ready_out, 0);
    end
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    tick();
    check("stall.next_chan", chan_out, 1);
    check("stall.next_acc", acc_out, 0);
    tick();
    tick();
    tick();
    check("stall.done_busy", busy_out, 0);
    ready_in = 1'b0;

    // Reset pulse during the ch1 word; ch3 content must be wiped too.
    add(2'd1, 8'd5);
    add(2'd3, 8'd6);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    tick();
    tick();
    check("prerst.chan", chan_out, 1);
    check("prerst.acc", acc_out, 5);
    rst_n = 1'b0;
    #1;
    check("midrst.valid", valid_out, 0);
    check("midrst.chan", chan_out, 0);
    check("midrst.acc", acc_out, 0);
    check("midrst.ovf", ovf_out, 0);
    check("midrst.busy", busy_out, 0);
    #1;
    rst_n = 1'b1;
    ready_in = 1'b0;
    @(negedge clk);
    check("postrst.ready", ready_out, 1);
    do_dump("fresh", 10'd0, 10'd0, 10'd0, 10'd0, 4'b0000);

    // Clear together with an accept on ch3, then clear aborting a readout.
    drive(1'b1, 1'b1, 2'd3, 8'd9, 1'b0, 1'b0);
    tick();
    check("clr.ready", ready_out, 1);
    check("clr.busy", busy_out, 0);
    add(2'd2, 8'd4);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
    tick();
    dump = 1'b0;
    tick();
    check("clrdump.valid_before", valid_out, 1);
    drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    tick();
    check("clrdump.valid", valid_out, 0);
    check("clrdump.busy", busy_out, 0);
    check("clrdump.ready", ready_out, 1);
    clr = 1'b0;
    do_dump("afterclr", 10'd0, 10'd0, 10'd0, 10'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
